// File: rtl/liteeth_sram_fifo_ctrl.sv
// rtl/liteeth_sram_fifo_ctrl.sv - word FIFO controller around a 1RW+1R SRAM macro with a 2-entry output buffer
// Optional: define LITEETH_SRAM_FIFO_LEVEL_EN to add the registered level/almost_full ports.
module liteeth_sram_fifo_ctrl #(
  parameter int BITS        = 32,
  parameter int WORD_DEPTH  = 384,
  parameter int ADDR_WIDTH  = 9,
  parameter int LEVEL_WIDTH = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic [BITS-1:0]        sink_data,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic [BITS-1:0]        source_data,
  output logic                   rw0_ce_in,
  output logic                   rw0_we_in,
  output logic [ADDR_WIDTH-1:0]  rw0_addr_in,
  output logic [BITS-1:0]        rw0_wd_in,
  output logic                   r0_ce_in,
  output logic [ADDR_WIDTH-1:0]  r0_addr_in,
  input  logic [BITS-1:0]        r0_rd_out
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  ,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         sram_count, sram_count_nxt;
  logic                  inflight, inflight_nxt;
  logic [1:0]            ob_count, ob_count_nxt;
  logic [BITS-1:0]       ob_head, ob_tail, ob_head_nxt, ob_tail_nxt;
  logic [1:0]            occ;
  logic                  push, pop, issue;

  assign sink_ready   = !sys_rst && (sram_count != DEPTH_C);
  assign source_valid = (ob_count != 2'd0);
  assign source_data  = ob_head;

  assign push = sink_valid && sink_ready;
  assign pop  = !sys_rst && source_valid && source_ready;
  assign occ  = ob_count + {1'b0, inflight};

  // Only issue a read when the output buffer is guaranteed a slot for its data next cycle.
  always_comb begin
    issue = 1'b0;
    if (!sys_rst && (sram_count != '0))
      issue = pop ? (occ < 2'd3) : (occ < 2'd2);
  end

  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    sram_count_nxt = sram_count;
    inflight_nxt   = issue;
    if (push)
      wr_ptr_nxt = (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
    if (issue)
      rd_ptr_nxt = (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
    case ({push, issue})
      2'b10:   sram_count_nxt = sram_count + 1'b1;
      2'b01:   sram_count_nxt = sram_count - 1'b1;
      default: sram_count_nxt = sram_count;
    endcase
  end

  // Output buffer: head is presented, tail only ever holds the second word.
  // r0_rd_out is sampled solely when a read was issued last cycle.
  always_comb begin
    ob_count_nxt = ob_count;
    ob_head_nxt  = ob_head;
    ob_tail_nxt  = ob_tail;
    case ({inflight, pop})
      2'b01: begin
        ob_count_nxt = ob_count - 2'd1;
        if (ob_count == 2'd2)
          ob_head_nxt = ob_tail;
      end
      2'b10: begin
        ob_count_nxt = ob_count + 2'd1;
        if (ob_count == 2'd0)
          ob_head_nxt = r0_rd_out;
        else
          ob_tail_nxt = r0_rd_out;
      end
      2'b11: begin
        if (ob_count == 2'd2) begin
          ob_head_nxt = ob_tail;
          ob_tail_nxt = r0_rd_out;
        end else begin
          ob_head_nxt = r0_rd_out;
        end
      end
      default: ob_count_nxt = ob_count;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sram_count <= '0;
      inflight   <= 1'b0;
      ob_count   <= 2'd0;
      ob_head    <= '0;
      ob_tail    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      sram_count <= sram_count_nxt;
      inflight   <= inflight_nxt;
      ob_count   <= ob_count_nxt;
      ob_head    <= ob_head_nxt;
      ob_tail    <= ob_tail_nxt;
    end
  end

  always_comb begin
    rw0_ce_in   = push;
    rw0_we_in   = push;
    rw0_addr_in = push ? wr_ptr : '0;
    rw0_wd_in   = push ? sink_data : '0;
    r0_ce_in    = issue;
    r0_addr_in  = issue ? rd_ptr : '0;
  end

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  logic [LEVEL_WIDTH-1:0] level_nxt;

  assign level_nxt = LEVEL_WIDTH'(sram_count_nxt) + LEVEL_WIDTH'(inflight_nxt)
                   + LEVEL_WIDTH'(ob_count_nxt);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_nxt;
      almost_full <= (level_nxt >= LEVEL_WIDTH'(WORD_DEPTH - 16));
    end
  end
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb/tb_liteeth_sram_fifo_ctrl.sv - directed/random bench for liteeth_sram_fifo_ctrl with a behavioural SRAM macro
module tb_liteeth_sram_fifo_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic [31:0] sink_data = '0;
  logic        source_valid;
  logic        source_ready = 1'b0;
  logic [31:0] source_data;
  logic        rw0_ce_in, rw0_we_in, r0_ce_in;
  logic [8:0]  rw0_addr_in, r0_addr_in;
  logic [31:0] rw0_wd_in;
  logic [31:0] r0_rd_out = 32'hBADC0DE0;
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  logic [9:0]  level;
  logic        almost_full;
`endif

  always #5 sys_clk = ~sys_clk;

  liteeth_sram_fifo_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_data    (sink_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .rw0_ce_in    (rw0_ce_in),
    .rw0_we_in    (rw0_we_in),
    .rw0_addr_in  (rw0_addr_in),
    .rw0_wd_in    (rw0_wd_in),
    .r0_ce_in     (r0_ce_in),
    .r0_addr_in   (r0_addr_in),
    .r0_rd_out    (r0_rd_out)
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    ,
    .level        (level),
    .almost_full  (almost_full)
`endif
  );

  // Behavioural macro: read data is garbage unless a read was issued last cycle.
  logic [31:0] mem [0:383];
  logic [31:0] garbage = 32'hBADC0DE0;
  always @(posedge sys_clk) begin
    garbage <= garbage + 32'h11;
    if (rw0_ce_in && rw0_we_in) mem[rw0_addr_in] <= rw0_wd_in;
    if (r0_ce_in) r0_rd_out <= mem[r0_addr_in];
    else          r0_rd_out <= garbage;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_push = 0;
  int n_pop = 0;
  int last_pop_cyc = 0;
  int wraps = 0;
  logic push_f, pop_f;
  logic [31:0] last_pop = '0;
  logic [8:0]  exp_wr = '0;
  logic [8:0]  prev_wr = '0;
  logic [31:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, sample at negedge+1, model the handshakes of this cycle.
  task automatic cycle(input logic rst, input logic sv, input logic [31:0] sd, input logic sr);
    logic [31:0] e;
    @(negedge sys_clk);
    sys_rst = rst; sink_valid = sv; sink_data = sd; source_ready = sr;
    #1;
    cyc++;
    push_f = 1'b0;
    pop_f  = 1'b0;
    if (rst) begin
      q.delete();
      exp_wr = '0;
    end else begin
      push_f = sv && sink_ready;
      pop_f  = source_valid && sr;
      check("rw0_ce", {31'd0, rw0_ce_in}, {31'd0, push_f});
      if (pop_f) begin
        if (q.size() == 0) begin
          check("pop_when_empty", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("pop_data", source_data, e);
        end
        last_pop = source_data;
        last_pop_cyc = cyc;
        n_pop++;
      end
      if (push_f) begin
        check("wr_addr", {23'd0, rw0_addr_in}, {23'd0, exp_wr});
        check("wr_data", rw0_wd_in, sd);
        check("rw0_we", {31'd0, rw0_we_in}, 32'd1);
        if (rw0_addr_in == 9'd0 && prev_wr == 9'd383) wraps++;
        prev_wr = rw0_addr_in;
        q.push_back(sd);
        n_push++;
        exp_wr = (exp_wr == 9'd383) ? 9'd0 : exp_wr + 9'd1;
      end
      if (rw0_ce_in && r0_ce_in && rw0_addr_in == r0_addr_in)
        check("addr_clash", 32'd1, 32'd0);
    end
  endtask

  task automatic drain(input int bound);
    int g = 0;
    while (q.size() > 0 && g < bound) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      g++;
    end
    check("drain_done", q.size(), 32'd0);
  endtask

  initial begin
    int p0, c0, first_pop, g;

    // Reset
    repeat (3) begin
      cycle(1'b1, 1'b1, 32'h1234, 1'b1);
      check("rst_sink_ready", {31'd0, sink_ready}, 32'd0);
      check("rst_rw0_ce", {31'd0, rw0_ce_in}, 32'd0);
      check("rst_r0_ce", {31'd0, r0_ce_in}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check("post_rst_valid", {31'd0, source_valid}, 32'd0);
    check("post_rst_ready", {31'd0, sink_ready}, 32'd1);
    check("post_rst_r0_addr", {23'd0, r0_addr_in}, 32'd0);
    check("post_rst_data", source_data, 32'd0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    check("post_rst_level", {22'd0, level}, 32'd0);
`endif

    // Single word latency
    cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    check("single_push", {31'd0, push_f}, 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("lat_c1_valid", {31'd0, source_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("lat_c2_valid", {31'd0, source_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("lat_c3_valid", {31'd0, source_valid}, 32'd1);
    check("lat_c3_data", source_data, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("lat_c4_valid", {31'd0, source_valid}, 32'd0);
    check("hold_data", source_data, 32'hDEADBEEF);

    // Fill with source stalled
    p0 = n_push;
    for (int i = 0; i < 400; i++) cycle(1'b0, 1'b1, i, 1'b0);
    check("fill_accepted", n_push - p0, 32'd386);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check("full_ready", {31'd0, sink_ready}, 32'd0);
    check("full_valid", {31'd0, source_valid}, 32'd1);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    check("full_level", {22'd0, level}, 32'd386);
    check("full_almost", {31'd0, almost_full}, 32'd1);
`endif
    cycle(1'b0, 1'b1, 32'hAAAA0000, 1'b1);
    check("full_pop_ready", {31'd0, sink_ready}, 32'd0);
    check("full_pop_fired", {31'd0, pop_f}, 32'd1);
    cycle(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
    check("refill_ready", {31'd0, sink_ready}, 32'd1);
    check("refill_push", {31'd0, push_f}, 32'd1);
    drain(1000);
    check("refill_last", last_pop, 32'h5A5A5A5A);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("drained_valid", {31'd0, source_valid}, 32'd0);

    // Streaming, one word per cycle
    p0 = n_pop; c0 = cyc + 1; first_pop = -1; wraps = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 1'b1, i, 1'b1);
      if (pop_f && first_pop < 0) first_pop = cyc - c0;
    end
    g = 0;
    while (n_pop - p0 < 1000 && g < 20) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      g++;
    end
    check("stream_first", first_pop, 32'd3);
    check("stream_last", last_pop_cyc - c0, 32'd1002);
    check("stream_count", n_pop - p0, 32'd1000);
    check("stream_last_data", last_pop, 32'd999);
    check("stream_wrapped", {31'd0, wraps > 0}, 32'd1);

    // Random valid/ready, 5000 words
    p0 = n_push; g = 0;
    while ((n_push - p0 < 5000 || q.size() > 0) && g < 40000) begin
      cycle(1'b0, (n_push - p0 < 5000) ? 1'($urandom_range(0, 1)) : 1'b0,
            $urandom, 1'($urandom_range(0, 1)));
      g++;
    end
    check("rand_pushed", n_push - p0, 32'd5000);
    check("rand_empty", q.size(), 32'd0);

    // Reset with words buffered and a read in flight
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'h100 + i, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("mid_pop", {31'd0, pop_f}, 32'd1);
    check("mid_issue", {31'd0, r0_ce_in}, 32'd1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check("mid_rst_valid", {31'd0, source_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, sink_ready}, 32'd1);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    check("mid_rst_level", {22'd0, level}, 32'd0);
`endif
    p0 = n_pop;
    cycle(1'b0, 1'b1, 32'h1, 1'b1);
    drain(20);
    check("mid_first_out", last_pop, 32'h1);
    check("mid_out_count", n_pop - p0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
